svc_rv_stage_wb_ret: RTL
========================

# svc_rv_stage_wb_ret

Parametrised write-back/retire stage for the svc RISC-V pipeline. It selects the register-file write data, counts retired instructions, latches a sticky halt state on EBREAK or trap, and pushes one trace record per retired instruction into an internal FIFO for a debug or trace consumer. The block sits after MEM and feeds `rd_data_wb` back to the ID-stage register file. It also exports the `instret` count for the CSR unit.

## Interface
- `XLEN`, 32: datapath width (32 or 64).
- `RES_N`, 6: number of result sources in the `res_data_wb` vector (2..8).
- `TRACE_DEPTH`, 8: trace FIFO entries; must be a power of 2 and ≥ 2.
- `TRACE_STALL`, 0: FIFO-full policy. 1 = hold the pipeline via `stall_wb`; 0 = drop the record and set `trace_overflow`.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `valid_wb`  in  1  WB holds a real instruction.
- `res_src_wb`  in  3  result select; values ≥ `RES_N` select 0.
- `res_data_wb`  in  `RES_N*XLEN`  flat result vector; source k occupies bits `[k*XLEN +: XLEN]`.
- `instr_wb`  in  32  instruction word.
- `pc_wb`  in  XLEN  instruction PC.
- `rd_wb`  in  5  destination register.
- `reg_write_wb`  in  1  instruction writes rd.
- `trap_wb`  in  1  instruction trapped.
- `rd_data_wb`  out  XLEN  selected write-back data (combinational).
- `reg_write_en`  out  1  gated register-file write enable.
- `stall_wb`  out  1  back-pressure to the pipeline (`TRACE_STALL=1` only; otherwise tied 0).
- `halted`  out  1  sticky halt flag.
- `halt_cause`  out  2  0 none, 1 ebreak, 2 trap.
- `instret`  out  64  retired-instruction count.
- `trace_valid`  out  1  FIFO head is valid.
- `trace_ready`  in  1  consumer accepts the head record.
- `trace_pc`  out  XLEN  PC field of the head record.
- `trace_instr`  out  32  instruction field of the head record.
- `trace_rd`  out  5  rd field of the head record.
- `trace_we`  out  1  write-enable field of the head record.
- `trace_data`  out  XLEN  write-data field of the head record.
- `trace_overflow`  out  1  sticky; at least one record was dropped.

## Operation
- Retire event: `ret = valid_wb && !halted && !stall_wb`.
- The halting instruction (EBREAK, `I_EBREAK` encoding, or `trap_wb`) does **not** retire:
  - no `instret` increment;
  - `reg_write_en` = 0;
  - a trace record is still pushed with `we` forced to 0.
- If `trap_wb` and EBREAK occur together, trap wins (`halt_cause` = 2).
- `reg_write_en = ret && reg_write_wb && rd_wb != 0 && !halting`.
- Halt FSM:
  - RUN → HALTED when `valid_wb && !stall_wb && (ebreak || trap_wb)`.
  - HALTED exits only on reset.
  - While HALTED, all WB inputs are ignored.
- `instret`:
  - 64-bit, increments by 1 per non-halting retire;
  - wraps from 2^64−1 to 0.
- Trace push: `push = valid_wb && !halted && !stall_wb`.
  - Record = {`pc_wb`, `instr_wb`, `rd_wb`, `reg_write_en`, `rd_data_wb`}.
- Trace pop: `trace_valid && trace_ready`.
- FIFO full:
  - `TRACE_STALL=1`: `stall_wb` = `valid_wb && full && !pop`. A simultaneous pop frees the slot, so there is no stall.
  - `TRACE_STALL=0`: the push is discarded, `trace_overflow` is set, and the instruction still retires normally.
- Push and pop in the same cycle:
  - when full: allowed, occupancy unchanged;
  - when empty: the push is not visible the same cycle (no bypass).

## Timing
- `rd_data_wb`, `reg_write_en` and `stall_wb` are combinational from inputs and state.
- `instret`, `halted` and `halt_cause` update on the edge after the event.
- A pushed record appears on `trace_*` one cycle after the push; the trace interface has no fall-through.
- `trace_*` fields are stable while `trace_valid && !trace_ready`.
- Reset values:
  - `halted` = 0, `halt_cause` = 0, `instret` = 0;
  - FIFO empty, `trace_valid` = 0, `trace_overflow` = 0, `stall_wb` = 0;
  - trace data fields = 0.
- Reset mid-operation flushes all FIFO contents and clears the halt state.

## Structure
- `svc_rv_pkg` holds the `halt_cause_t` enum (`HALT_NONE`, `HALT_EBREAK`, `HALT_TRAP`) and the `I_EBREAK` constant.
- Sub-module `svc_rv_trace_fifo`:
  - parametrised on width and depth;
  - read/write pointers one bit wider than the address for full/empty detection;
  - registered head output.
- Result selection reuses `svc_muxn`.

## Test plan
1. Reset, then 5 valid ALU instructions with `res_src`=0, rd=3, data 0x10..0x14 → `instret`=5; 5 trace records in order with `we`=1; `rd_data_wb` equals the selected source each cycle.
2. `reg_write_wb`=1 with rd=0 → `reg_write_en`=0, and the trace record shows `we`=0.
3. EBREAK at PC 0x100 → next cycle `halted`=1, `halt_cause`=1, `instret` unchanged; later valid instructions produce no pushes and no writes.
4. `trap_wb` and EBREAK in the same cycle → `halt_cause`=2.
5. `TRACE_DEPTH`=4, `TRACE_STALL`=0, `trace_ready`=0, 6 retires → 4 records held, `trace_overflow`=1, `instret`=6.
6. `TRACE_STALL`=1 with the FIFO full:
   - valid instruction with `trace_ready`=0 → `stall_wb`=1 and no retire;
   - same instruction with `trace_ready`=1 → no stall, and push and pop occur together;
   - reset asserted mid-stream → FIFO empty and `instret`=0 on the next cycle.

Source files
------------

// File: rtl/svc_rv_pkg.sv
// Shared types and constants for the svc RISC-V write-back/retire stage.
package svc_rv_pkg;

    // Why the core stopped; held until reset.
    typedef enum logic [1:0] {
        HALT_NONE   = 2'd0,
        HALT_EBREAK = 2'd1,
        HALT_TRAP   = 2'd2
    } halt_cause_t;

    // Write-back halt state machine.
    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } wb_state_t;

    // Canonical EBREAK encoding (SYSTEM opcode, funct12 = 1).
    localparam logic [31:0] I_EBREAK = 32'h0010_0073;

    function automatic logic is_ebreak(input logic [31:0] instr);
        return instr == I_EBREAK;
    endfunction

endpackage

// File: rtl/svc_muxn.sv
// N-way one-of mux over a flat input vector; out-of-range selects pick source 0.
module svc_muxn #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned N     = 2,
    parameter int unsigned SEL_W = 3
) (
    input  logic [SEL_W-1:0]   sel,
    input  logic [N*WIDTH-1:0] data,
    output logic [WIDTH-1:0]   y
);

    // Default to source 0, override with the matching in-range source.
    always_comb begin
        y = data[WIDTH-1:0];
        for (int unsigned k = 0; k < N; k++) begin
            if (32'(sel) == k) begin
                y = data[k*WIDTH +: WIDTH];
            end
        end
    end

endmodule

// File: rtl/svc_rv_trace_fifo.sv
// Trace record FIFO with a registered head (no fall-through).
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module svc_rv_trace_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_ready,
    output logic             rd_valid,
    output logic [WIDTH-1:0] rd_data,
    output logic             full
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [AW:0]      wr_ptr_nxt;
    logic [AW:0]      rd_ptr_nxt;
    logic             push;
    logic             pop;
    logic             head_from_wr;

    assign full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop  = rd_valid && rd_ready;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign push = wr_en && (!full || pop);

    // Next pointer values; the head register is reloaded from these.
    always_comb begin
        wr_ptr_nxt   = wr_ptr + (AW+1)'(push);
        rd_ptr_nxt   = rd_ptr + (AW+1)'(pop);
        // The entry becoming head is the one being written this very cycle.
        head_from_wr = push && (wr_ptr[AW-1:0] == rd_ptr_nxt[AW-1:0]);
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

    // Pointers and registered head; head holds when the FIFO drains.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            wr_ptr   <= wr_ptr_nxt;
            rd_ptr   <= rd_ptr_nxt;
            rd_valid <= (wr_ptr_nxt != rd_ptr_nxt);
            if (wr_ptr_nxt != rd_ptr_nxt) begin
                rd_data <= head_from_wr ? wr_data : mem[rd_ptr_nxt[AW-1:0]];
            end
        end
    end

endmodule

// File: rtl/svc_rv_stage_wb_ret.sv
// Write-back/retire stage: result select, instret, sticky halt, trace FIFO.
module svc_rv_stage_wb_ret
    import svc_rv_pkg::*;
#(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned RES_N       = 6,
    parameter int unsigned TRACE_DEPTH = 8,
    parameter int unsigned TRACE_STALL = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  valid_wb,
    input  logic [2:0]            res_src_wb,
    input  logic [RES_N*XLEN-1:0] res_data_wb,
    input  logic [31:0]           instr_wb,
    input  logic [XLEN-1:0]       pc_wb,
    input  logic [4:0]            rd_wb,
    input  logic                  reg_write_wb,
    input  logic                  trap_wb,
    output logic [XLEN-1:0]       rd_data_wb,
    output logic                  reg_write_en,
    output logic                  stall_wb,
    output logic                  halted,
    output logic [1:0]            halt_cause,
    output logic [63:0]           instret,
    output logic                  trace_valid,
    input  logic                  trace_ready,
    output logic [XLEN-1:0]       trace_pc,
    output logic [31:0]           trace_instr,
    output logic [4:0]            trace_rd,
    output logic                  trace_we,
    output logic [XLEN-1:0]       trace_data,
    output logic                  trace_overflow
);

    // Record layout: {pc, instr, rd, we, data}.
    localparam int unsigned REC_W = 2*XLEN + 32 + 5 + 1;

    wb_state_t        state;
    halt_cause_t      cause_q;
    logic             fifo_full;
    logic             trace_pop;
    logic             halt_req;
    logic             accept;
    logic             halting;
    logic             retire;
    logic [REC_W-1:0] rec_in;
    logic [REC_W-1:0] rec_out;

    svc_muxn #(
        .WIDTH (XLEN),
        .N     (RES_N),
        .SEL_W (3)
    ) u_res_mux (
        .sel  (res_src_wb),
        .data (res_data_wb),
        .y    (rd_data_wb)
    );

    assign trace_pop = trace_valid && trace_ready;
    assign halt_req  = is_ebreak(instr_wb) || trap_wb;

    // Qualify the WB slot: accept, halting vs. retiring, and gated write-enable.
    always_comb begin
        stall_wb     = (TRACE_STALL != 0) && valid_wb && fifo_full && !trace_pop;
        accept       = valid_wb && !halted && !stall_wb;
        halting      = accept && halt_req;
        retire       = accept && !halt_req;
        reg_write_en = retire && reg_write_wb && (rd_wb != 5'd0);
    end

    // Halt FSM: enter HALTED on EBREAK/trap, trap taking priority as the cause.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ST_RUN;
            cause_q <= HALT_NONE;
            halted  <= 1'b0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (halting) begin
                        state   <= ST_HALTED;
                        halted  <= 1'b1;
                        cause_q <= trap_wb ? HALT_TRAP : HALT_EBREAK;
                    end
                end
                ST_HALTED: begin
                    state  <= ST_HALTED;
                    halted <= 1'b1;
                end
                default: begin
                    state   <= ST_RUN;
                    cause_q <= HALT_NONE;
                    halted  <= 1'b0;
                end
            endcase
        end
    end

    assign halt_cause = cause_q;

    // Retired-instruction counter; wraps naturally at 2^64.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            instret <= '0;
        end else if (retire) begin
            instret <= instret + 64'd1;
        end
    end

    // Sticky drop flag; only reachable when full does not stall the pipe.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            trace_overflow <= 1'b0;
        end else if (accept && fifo_full && !trace_pop) begin
            trace_overflow <= 1'b1;
        end
    end

    assign rec_in = {pc_wb, instr_wb, rd_wb, reg_write_en, rd_data_wb};

    svc_rv_trace_fifo #(
        .WIDTH (REC_W),
        .DEPTH (TRACE_DEPTH)
    ) u_trace_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (accept),
        .wr_data  (rec_in),
        .rd_ready (trace_ready),
        .rd_valid (trace_valid),
        .rd_data  (rec_out),
        .full     (fifo_full)
    );

    assign {trace_pc, trace_instr, trace_rd, trace_we, trace_data} = rec_out;

endmodule
